// File: rtl/arm_pipeline_pkg.sv
// Shared definitions for the ARM32 pipeline units: NOP encoding, fetch FSM states
// and the fetch-side instruction/address payload.
package arm_pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'hE320_F000;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Single-entry skid buffer holding a fetched word that arrived while decode was stalled.
module fetch_hold_buffer
    import arm_pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        unload_i,
    input  fetch_word_t word_i,
    output fetch_word_t word_o,
    output logic        full_o
);

    fetch_word_t word_q;
    logic        full_q;

    // Clear/unload win over load; the payload is only rewritten on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            full_q <= 1'b0;
        end else if (clear_i || unload_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            word_q <= word_i;
            full_q <= 1'b1;
        end
    end

    assign word_o = word_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_pipeline_unit.sv
// Fetch stage: PC generation, single-outstanding instruction memory requests,
// stall absorption via a hold buffer, and branch squash with NOP injection.
module fetch_pipeline_unit
    import arm_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;

    logic         hb_load, hb_clear, hb_unload, hb_full;
    logic         out_loaded;
    fetch_word_t  hb_word_in, hb_word_out;

    assign hb_word_in = '{instr: imem_rdata, pc: pc_q};

    fetch_hold_buffer u_hold_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (hb_load),
        .clear_i  (hb_clear),
        .unload_i (hb_unload),
        .word_i   (hb_word_in),
        .word_o   (hb_word_out),
        .full_o   (hb_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= REQ;
            pc_q     <= word_align(RESET_PC);
            instr_q  <= NOP_INSTR;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        hb_load    = 1'b0;
        hb_clear   = 1'b0;
        hb_unload  = 1'b0;
        out_loaded = 1'b0;

        case (state_q)
            REQ: state_d = WAIT;
            WAIT: begin
                if (imem_valid) begin
                    pc_d = pc_q + 32'd4;
                    if (!stall) begin
                        instr_d    = imem_rdata;
                        pc_out_d   = pc_q;
                        valid_d    = 1'b1;
                        out_loaded = 1'b1;
                        state_d    = REQ;
                    end else begin
                        hb_load = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    instr_d    = hb_word_out.instr;
                    pc_out_d   = hb_word_out.pc;
                    valid_d    = 1'b1;
                    hb_unload  = 1'b1;
                    out_loaded = 1'b1;
                    state_d    = REQ;
                end
            end
            DRAIN: if (imem_valid) state_d = REQ;
            default: state_d = REQ;
        endcase

        // Decode consumes the output every unstalled cycle; refill with a bubble.
        if (!stall && !out_loaded) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        // Redirect overrides stall and any load decided above.
        if (branch_taken) begin
            pc_d      = word_align(branch_target);
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            pc_out_d  = pc_out_q;
            hb_load   = 1'b0;
            hb_unload = 1'b0;
            hb_clear  = 1'b1;
            if (state_q == REQ) begin
                state_d = DRAIN;
            end else if (state_q == HOLD) begin
                state_d = REQ;
            end else begin
                state_d = imem_valid ? REQ : DRAIN;
            end
        end
    end

    // The request strobe is a decode of the state, masked while reset is held.
    assign imem_req    = rst_n && (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

    assert property (@(posedge clk) disable iff (!rst_n)
        imem_valid |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_fetch_pipeline_unit.sv
// Randomized bench for fetch_pipeline_unit with a transaction-level reference model
// and a latency-randomized instruction memory.
module tb_fetch_pipeline_unit;

    localparam logic [31:0] TB_NOP = 32'hE320_F000;
    localparam int unsigned N_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    fetch_pipeline_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: next fetch address, decode-facing output, request tracking.
    logic [31:0] m_pc, m_instr, m_pcout, m_hinstr, m_hpc;
    bit          m_valid, m_out, m_disc, m_held;

    // Memory model: one pending response with a countdown.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1001;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = TB_NOP; m_pcout = 32'h0; m_valid = 1'b0;
        m_out = 1'b0; m_disc = 1'b0; m_held = 1'b0; m_hinstr = '0; m_hpc = '0;
    endtask

    task automatic compare_all();
        bit req;
        req = !m_out && !m_held;
        check("imem_req", 32'(imem_req), 32'(req));
        if (req) check("imem_addr", imem_addr, m_pc);
        check("instr_out", instr_out, m_instr);
        check("pc_out", pc_out, m_pcout);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
    endtask

    task automatic model_step(input bit st, input bit br, input logic [31:0] tgt,
                              input bit iv, input logic [31:0] rd);
        bit req;
        bit loaded;
        req = !m_out && !m_held;
        loaded = 1'b0;
        if (br) begin
            m_pc = {tgt[31:2], 2'b00};
            m_instr = TB_NOP;
            m_valid = 1'b0;
            m_held = 1'b0;
            if (req) begin
                m_out = 1'b1; m_disc = 1'b1;
            end else if (iv) begin
                m_out = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            if (req) begin
                m_out = 1'b1; m_disc = 1'b0;
            end else if (m_out && iv) begin
                m_out = 1'b0;
                if (!m_disc) begin
                    if (!st) begin
                        m_instr = rd; m_pcout = m_pc; m_valid = 1'b1; loaded = 1'b1;
                    end else begin
                        m_held = 1'b1; m_hinstr = rd; m_hpc = m_pc;
                    end
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_held && !st) begin
                m_instr = m_hinstr; m_pcout = m_hpc; m_valid = 1'b1;
                m_held = 1'b0; loaded = 1'b1;
            end
            if (!st && !loaded) begin
                m_instr = TB_NOP; m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'h0);
        check({tag, "_instr"}, instr_out, TB_NOP);
        check({tag, "_pc"}, pc_out, 32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
    endtask

    initial begin
        bit          st, br, iv, want_reset;
        logic [31:0] tgt, rd;
        int          lat;

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        model_reset();
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
        want_reset = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc < int'(N_CYCLES); cyc++) begin
            #1;
            compare_all();

            // Hand-derived checkpoints for the directed opening sequence.
            case (cyc)
                0: begin
                    check("c0_req", 32'(imem_req), 32'h1);
                    check("c0_addr", imem_addr, 32'h0);
                end
                2: begin
                    check("c2_instr", instr_out, 32'hE3A0_1001);
                    check("c2_pc", pc_out, 32'h0);
                    check("c2_valid", 32'(instr_valid), 32'h1);
                    check("c2_addr", imem_addr, 32'h4);
                end
                4: begin
                    check("c4_req", 32'(imem_req), 32'h0);
                    check("c4_valid", 32'(instr_valid), 32'h0);
                end
                6: begin
                    check("c6_req", 32'(imem_req), 32'h1);
                    check("c6_addr", imem_addr, 32'h0000_0100);
                    check("c6_valid", 32'(instr_valid), 32'h0);
                end
                10: begin
                    check("c10_req", 32'(imem_req), 32'h0);
                    check("c10_pc", pc_out, 32'h0000_0100);
                    check("c10_valid", 32'(instr_valid), 32'h1);
                end
                13: begin
                    check("c13_pc", pc_out, 32'h0000_0104);
                    check("c13_valid", 32'(instr_valid), 32'h1);
                    check("c13_addr", imem_addr, 32'h0000_0108);
                end
                15: begin
                    check("c15_instr", instr_out, TB_NOP);
                    check("c15_valid", 32'(instr_valid), 32'h0);
                    check("c15_addr", imem_addr, 32'hFFFF_FFFC);
                end
                17: begin
                    check("c17_pc", pc_out, 32'hFFFF_FFFC);
                    check("c17_valid", 32'(instr_valid), 32'h1);
                    check("c17_addr", imem_addr, 32'h0000_0000);
                end
                default: ;
            endcase

            if (cyc >= 18 && (cyc % 500) == 0) want_reset = 1'b1;
            if (want_reset && m_out && !m_disc) begin
                // Asynchronous reset in the middle of an outstanding fetch.
                want_reset = 1'b0;
                rst_n = 1'b0;
                stall = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
                #1;
                check_reset_outputs("midreset");
                model_reset();
                mem_pend = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                continue;
            end

            iv = mem_pend && (mem_cnt == 0);
            if (mem_pend && mem_cnt != 0) mem_cnt--;
            if (iv) mem_pend = 1'b0;
            rd = iv ? mem_word(mem_addr) : $urandom();

            if (cyc < 18) begin
                lat = (cyc == 2) ? 3 : 1;
                st  = (cyc >= 8 && cyc <= 11) || cyc == 14;
                br  = (cyc == 3) || (cyc == 14);
                tgt = (cyc == 3) ? 32'h0000_0103 : 32'hFFFF_FFFF;
            end else begin
                lat = int'($urandom_range(1, 4));
                st  = ($urandom_range(0, 99) < 30);
                br  = ($urandom_range(0, 99) < 4);
                case ($urandom_range(0, 3))
                    0: tgt = 32'h0000_0103;
                    1: tgt = 32'hFFFF_FFFF;
                    2: tgt = 32'hFFFF_FFF4;
                    default: tgt = $urandom();
                endcase
            end

            if (imem_req) begin
                mem_pend = 1'b1;
                mem_cnt  = lat - 1;
                mem_addr = imem_addr;
            end

            stall = st; branch_taken = br; branch_target = tgt;
            imem_valid = iv; imem_rdata = rd;
            model_step(st, br, tgt, iv, rd);

            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
